sha3_state_slicer: RTL and testbench

SHA3_STATE_SLICER -- requirements
Module: sha3_state_slicer

---
 rtl/sha3_state_slicer.sv | 147 ++++++++++++++
 tb/tb_sha3_state_slicer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_state_slicer.sv
// Captures a full 25-lane Keccak state and streams it out one 5-lane row at a time,
// with an optional second holding buffer so a following state can queue behind the current one.
module sha3_state_slicer #(
    parameter int PREFETCH = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         sample,
    input  logic [319:0] isa,
    input  logic [319:0] isb,
    input  logic [319:0] isc,
    input  logic [319:0] isd,
    input  logic [319:0] ise,
    output logic         ready,
    output logic [319:0] orow,
    output logic [2:0]   orow_idx,
    output logic         ovalid,
    input  logic         iready,
    output logic         olast,
    output logic         overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [1599:0]   w_q, w_d;
    logic [1599:0]   p_q, p_d;
    logic            p_full_q, p_full_d;
    logic            ready_q, ready_d;
    logic            overrun_q, overrun_d;

    logic [1599:0]   in_state;
    logic            handshake;
    logic            accept;
    logic            final_hs;

    // Row 0 (isa) sits in the low bits so row r is the 320-bit slice at 320*r.
    function automatic logic [319:0] select_row(input logic [1599:0] s, input logic [2:0] idx);
        logic [319:0] r;
        case (idx)
            3'd0:    r = s[319:0];
            3'd1:    r = s[639:320];
            3'd2:    r = s[959:640];
            3'd3:    r = s[1279:960];
            3'd4:    r = s[1599:1280];
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_state  = {ise, isd, isc, isb, isa};
    assign handshake = (state_q == SEND) && iready;
    assign accept    = sample && ready_q;
    assign final_hs  = handshake && (cnt_q == 3'd4);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        p_d       = p_q;
        p_full_d  = p_full_q;
        overrun_d = overrun_q;

        if (sample && !ready_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    w_d     = in_state;
                    cnt_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (final_hs) begin
                    // A queued state wins over a sample arriving on the same edge.
                    if (p_full_q) begin
                        w_d      = p_q;
                        p_full_d = 1'b0;
                        cnt_d    = 3'd0;
                    end else if (accept) begin
                        w_d   = in_state;
                        cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    if (handshake) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    if (accept && (PREFETCH != 0)) begin
                        p_d      = in_state;
                        p_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        // Ready is registered: it reflects the buffer occupancy after this edge.
        if (PREFETCH != 0) begin
            ready_d = !p_full_d;
        end else begin
            ready_d = (state_d == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            p_full_q  <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_full_q  <= p_full_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    // Lane storage carries no reset; occupancy is tracked by the control flops above.
    always_ff @(posedge clk) begin
        w_q <= w_d;
        p_q <= p_d;
    end

    assign ovalid   = (state_q == SEND);
    assign orow     = ovalid ? select_row(w_q, cnt_q) : '0;
    assign orow_idx = cnt_q;
    assign olast    = ovalid && (cnt_q == 3'd4);
    assign ready    = ready_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sha3_state_slicer.sv
// Directed bench for sha3_state_slicer: one instance with the pending buffer, one without.
module tb_sha3_state_slicer;

    logic         clk;
    logic         rstn;
    logic         sample, sample0;
    logic         iready, iready0;
    logic [319:0] isa, isb, isc, isd, ise;
    logic         ready, ready0;
    logic [319:0] orow, orow0;
    logic [2:0]   orow_idx, orow_idx0;
    logic         ovalid, ovalid0;
    logic         olast, olast0;
    logic         overrun, overrun0;

    int n_cmp;
    int n_fail;

    sha3_state_slicer #(.PREFETCH(1)) dut (
        .clk(clk), .rstn(rstn), .sample(sample),
        .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .ready(ready), .orow(orow), .orow_idx(orow_idx), .ovalid(ovalid),
        .iready(iready), .olast(olast), .overrun(overrun)
    );

    sha3_state_slicer #(.PREFETCH(0)) dut0 (
        .clk(clk), .rstn(rstn), .sample(sample0),
        .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .ready(ready0), .orow(orow0), .orow_idx(orow_idx0), .ovalid(ovalid0),
        .iready(iready0), .olast(olast0), .overrun(overrun0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane l of row r holds base + 0x100*r + l.
    function automatic logic [319:0] rowv(input logic [63:0] base, input int r);
        logic [319:0] v;
        for (int l = 0; l < 5; l++) begin
            v[64*l +: 64] = base + 64'(256 * r) + 64'(l);
        end
        return v;
    endfunction

    task automatic set_state(input logic [63:0] base);
        isa = rowv(base, 0);
        isb = rowv(base, 1);
        isc = rowv(base, 2);
        isd = rowv(base, 3);
        ise = rowv(base, 4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sample = 1'b0; sample0 = 1'b0; iready = 1'b0; iready0 = 1'b1;
        set_state(64'h0);
        tick();
        tick();
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid got %b want 0", ovalid); end
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_cmp++; if (olast !== 1'b0) begin n_fail++; $display("FAIL reset_olast got %b want 0", olast); end
        n_cmp++; if (orow_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", orow_idx); end
        n_cmp++; if (orow !== 320'd0) begin n_fail++; $display("FAIL reset_orow got %h want 0", orow); end
        n_cmp++; if ({ovalid0, ready0, overrun0} !== 3'b000) begin n_fail++; $display("FAIL reset_p0 got %b want 000", {ovalid0, ready0, overrun0}); end
        rstn = 1'b1;
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", ready); end
        n_cmp++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL release_ready_p0 got %b want 1", ready0); end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL release_ovalid got %b want 0", ovalid); end
    endtask

    task automatic test_basic();
        set_state(64'h0);
        sample = 1'b1; iready = 1'b1;
        tick();
        sample = 1'b0;
        for (int r = 0; r < 5; r++) begin
            n_cmp++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL basic_ovalid r%0d got %b want 1", r, ovalid); end
            n_cmp++; if (orow_idx !== 3'(r)) begin n_fail++; $display("FAIL basic_idx got %0d want %0d", orow_idx, r); end
            n_cmp++; if (orow !== rowv(64'h0, r)) begin n_fail++; $display("FAIL basic_row r%0d got %h want %h", r, orow, rowv(64'h0, r)); end
            n_cmp++; if (olast !== (r == 4)) begin n_fail++; $display("FAIL basic_olast r%0d got %b want %b", r, olast, (r == 4)); end
            tick();
        end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL basic_end_ovalid got %b want 0", ovalid); end
    endtask

    task automatic test_backpressure();
        int exp_r;
        int k;
        set_state(64'h9000);
        sample = 1'b1; iready = 1'b0;
        tick();
        sample = 1'b0;
        exp_r = 0;
        k = 0;
        while (exp_r < 5 && k < 40) begin
            n_cmp++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL bp_ovalid k%0d got %b want 1", k, ovalid); end
            n_cmp++; if (orow_idx !== 3'(exp_r)) begin n_fail++; $display("FAIL bp_idx k%0d got %0d want %0d", k, orow_idx, exp_r); end
            n_cmp++; if (orow !== rowv(64'h9000, exp_r)) begin n_fail++; $display("FAIL bp_row k%0d got %h want %h", k, orow, rowv(64'h9000, exp_r)); end
            iready = (k % 3 == 0);
            tick();
            if (iready) exp_r++;
            k++;
        end
        n_cmp++; if (exp_r !== 5) begin n_fail++; $display("FAIL bp_timeout rows %0d want 5", exp_r); end
        iready = 1'b1;
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL bp_end_ovalid got %b want 0", ovalid); end
    endtask

    task automatic test_prefetch();
        set_state(64'h1000);
        sample = 1'b1; iready = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        n_cmp++; if (orow_idx !== 3'd1) begin n_fail++; $display("FAIL pf_idx1 got %0d want 1", orow_idx); end
        set_state(64'h2000);
        sample = 1'b1;
        tick();
        sample = 1'b0;
        for (int r = 2; r < 5; r++) begin
            n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pf_ready r%0d got %b want 0", r, ready); end
            n_cmp++; if (orow !== rowv(64'h1000, r)) begin n_fail++; $display("FAIL pf_rowA r%0d got %h want %h", r, orow, rowv(64'h1000, r)); end
            tick();
        end
        for (int r = 0; r < 5; r++) begin
            n_cmp++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL pf_ovalidB r%0d got %b want 1", r, ovalid); end
            n_cmp++; if (orow_idx !== 3'(r)) begin n_fail++; $display("FAIL pf_idxB got %0d want %0d", orow_idx, r); end
            n_cmp++; if (orow !== rowv(64'h2000, r)) begin n_fail++; $display("FAIL pf_rowB r%0d got %h want %h", r, orow, rowv(64'h2000, r)); end
            if (r == 0) begin
                n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL pf_ready_drained got %b want 1", ready); end
            end
            tick();
        end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL pf_end_ovalid got %b want 0", ovalid); end
    endtask

    task automatic test_overrun();
        logic [63:0] b;
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ov_pre got %b want 0", overrun); end
        iready = 1'b0;
        set_state(64'h3000); sample = 1'b1;
        tick();
        set_state(64'h4000);
        tick();
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ov_ready got %b want 0", ready); end
        set_state(64'h5000);
        tick();
        sample = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ov_flag got %b want 1", overrun); end
        iready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b = (k < 5) ? 64'h3000 : 64'h4000;
            n_cmp++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL ov_ovalid k%0d got %b want 1", k, ovalid); end
            n_cmp++; if (orow !== rowv(b, k % 5)) begin n_fail++; $display("FAIL ov_row k%0d got %h want %h", k, orow, rowv(b, k % 5)); end
            tick();
        end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL ov_end_ovalid got %b want 0", ovalid); end
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ov_sticky got %b want 1", overrun); end
    endtask

    task automatic test_same_cycle();
        n_cmp++; if (overrun0 !== 1'b0) begin n_fail++; $display("FAIL sc_pre_p0 got %b want 0", overrun0); end
        set_state(64'h6000);
        sample = 1'b1; sample0 = 1'b1; iready = 1'b1; iready0 = 1'b1;
        tick();
        sample = 1'b0; sample0 = 1'b0;
        for (int r = 0; r < 4; r++) tick();
        n_cmp++; if (olast !== 1'b1) begin n_fail++; $display("FAIL sc_olast got %b want 1", olast); end
        n_cmp++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL sc_ready_p0 got %b want 0", ready0); end
        set_state(64'h7000);
        sample = 1'b1; sample0 = 1'b1;
        tick();
        sample = 1'b0; sample0 = 1'b0;
        n_cmp++; if (overrun0 !== 1'b1) begin n_fail++; $display("FAIL sc_overrun_p0 got %b want 1", overrun0); end
        n_cmp++; if (ovalid0 !== 1'b0) begin n_fail++; $display("FAIL sc_ovalid_p0 got %b want 0", ovalid0); end
        for (int r = 0; r < 5; r++) begin
            n_cmp++; if (ovalid !== 1'b1 || orow_idx !== 3'(r)) begin n_fail++; $display("FAIL sc_idx got v%b i%0d want v1 i%0d", ovalid, orow_idx, r); end
            n_cmp++; if (orow !== rowv(64'h7000, r)) begin n_fail++; $display("FAIL sc_row r%0d got %h want %h", r, orow, rowv(64'h7000, r)); end
            tick();
        end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL sc_end_ovalid got %b want 0", ovalid); end
    endtask

    task automatic test_reset_midstream();
        set_state(64'h8000);
        sample = 1'b1; iready = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        tick();
        n_cmp++; if (orow_idx !== 3'd2) begin n_fail++; $display("FAIL rm_idx2 got %0d want 2", orow_idx); end
        rstn = 1'b0; sample = 1'b1;
        tick();
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rm_ovalid got %b want 0", ovalid); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rm_overrun got %b want 0", overrun); end
        n_cmp++; if (overrun0 !== 1'b0) begin n_fail++; $display("FAIL rm_overrun_p0 got %b want 0", overrun0); end
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready got %b want 0", ready); end
        n_cmp++; if (orow !== 320'd0) begin n_fail++; $display("FAIL rm_orow got %h want 0", orow); end
        rstn = 1'b1; sample = 1'b0;
        tick();
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_rel got %b want 1", ready); end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rm_ovalid_rel got %b want 0", ovalid); end
        set_state(64'hA000);
        sample = 1'b1;
        tick();
        sample = 1'b0;
        for (int r = 0; r < 5; r++) begin
            n_cmp++; if (ovalid !== 1'b1 || orow_idx !== 3'(r)) begin n_fail++; $display("FAIL rm_idx got v%b i%0d want v1 i%0d", ovalid, orow_idx, r); end
            n_cmp++; if (orow !== rowv(64'hA000, r)) begin n_fail++; $display("FAIL rm_row r%0d got %h want %h", r, orow, rowv(64'hA000, r)); end
            tick();
        end
        n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rm_end_ovalid got %b want 0", ovalid); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_prefetch();
        test_overrun();
        test_same_cycle();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
